// File: rtl/ym_audio_pkg.sv
// Shared audio sample types and I2S frame constants for the ym audio path.
package ym_audio_pkg;
  localparam int SAMPLE_W   = 16;
  localparam int FRAME_BITS = 32;
  localparam int BIT_IDX_W  = $clog2(FRAME_BITS);

  typedef logic [SAMPLE_W-1:0]  sample_t;
  typedef logic [BIT_IDX_W-1:0] bit_idx_t;

  // Word select is high from the bit before the right MSB up to the bit before the next left MSB.
  localparam bit_idx_t LR_RISE_N = bit_idx_t'(15);
  localparam bit_idx_t LR_FALL_N = bit_idx_t'(31);
  localparam bit_idx_t LAST_BIT  = bit_idx_t'(FRAME_BITS-1);

  function automatic logic lr_of(input bit_idx_t n);
    return (n >= LR_RISE_N) && (n != LR_FALL_N);
  endfunction
endpackage

// File: rtl/ym_bclk_div.sv
// BCLK generator: divides phiM by 2*BCLK_DIV and flags the edge cycles.
module ym_bclk_div #(
  parameter int BCLK_DIV = 1
) (
  input  logic phiM,
  input  logic IC,
  output logic bclk,
  output logic fall_stb,
  output logic rise_stb
);
  localparam int CW = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(BCLK_DIV-1);

  logic [CW-1:0] div_cnt;
  logic          wrap;

  assign wrap     = (div_cnt == LAST);
  assign fall_stb = wrap & bclk;
  assign rise_stb = wrap & ~bclk;

  always_ff @(posedge phiM or posedge IC) begin
    if (IC) begin
      div_cnt <= '0;
      bclk    <= 1'b0;
    end else if (wrap) begin
      div_cnt <= '0;
      bclk    <= ~bclk;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end
endmodule

// File: rtl/ym_i2s_tx.sv
// Mono-to-stereo Philips I2S master transmitter with a one-sample holding register.
// Optional saturating underrun counter when YM_UNDERRUN_CNT_EN is defined.
module ym_i2s_tx
  import ym_audio_pkg::*;
#(
  parameter int BCLK_DIV = 1
) (
  input  logic        phiM,
  input  logic        IC,
`ifdef YM_UNDERRUN_CNT_EN
  input  logic        underrun_clr,
  output logic [7:0]  underrun_cnt,
`endif
  input  sample_t     sample_in,
  input  logic        sample_valid,
  output logic        sample_ready,
  output logic        bclk,
  output logic        lrclk,
  output logic        sdata,
  output logic        underrun
);
  logic                  fall_stb;
  logic                  full;
  sample_t               hold;
  logic [FRAME_BITS-1:0] shift;
  bit_idx_t              bit_cnt;
  bit_idx_t              n_next;

  ym_bclk_div #(.BCLK_DIV(BCLK_DIV)) u_div (
    .phiM     (phiM),
    .IC       (IC),
    .bclk     (bclk),
    .fall_stb (fall_stb),
    .rise_stb ()
  );

  assign sample_ready = ~full;
  assign n_next       = bit_cnt + 1'b1;

  always_ff @(posedge phiM or posedge IC) begin
    if (IC) begin
      lrclk    <= 1'b0;
      sdata    <= 1'b0;
      underrun <= 1'b0;
      hold     <= '0;
      full     <= 1'b0;
      shift    <= '0;
      bit_cnt  <= LAST_BIT;
    end else begin
      underrun <= 1'b0;
      if (fall_stb) begin
        bit_cnt <= n_next;
        lrclk   <= lr_of(n_next);
        if (n_next == '0) begin
          // hold is left intact so a starved frame replays the last sample
          shift <= {hold, hold};
          sdata <= hold[SAMPLE_W-1];
          if (full) full     <= 1'b0;
          else      underrun <= 1'b1;
        end else begin
          sdata <= shift[LAST_BIT - n_next];
        end
      end
      // full is clear here only when no frame-start consume happened this cycle
      if (sample_valid && !full) begin
        hold <= sample_in;
        full <= 1'b1;
      end
    end
  end

`ifdef YM_UNDERRUN_CNT_EN
  always_ff @(posedge phiM or posedge IC) begin
    if (IC)                                 underrun_cnt <= '0;
    else if (underrun_clr)                  underrun_cnt <= '0;
    else if (underrun && underrun_cnt != 8'hFF) underrun_cnt <= underrun_cnt + 1'b1;
  end
`endif
endmodule
